// File: rtl/simon_btn_encoder_pkg.sv
// Shared definitions for the Simon button encoder: move codes, FSM states
// and the one-hot button to code mapping.
package simon_btn_encoder_pkg;

   localparam int unsigned NUM_BTN = 4;
   localparam int unsigned CODE_W  = 2;

   localparam logic [CODE_W-1:0] CODE_GREEN  = 2'd0;
   localparam logic [CODE_W-1:0] CODE_RED    = 2'd1;
   localparam logic [CODE_W-1:0] CODE_YELLOW = 2'd2;
   localparam logic [CODE_W-1:0] CODE_BLUE   = 2'd3;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_REL = 1'b1
   } state_t;

   // Map a one-hot debounced button vector to its move code.
   function automatic logic [CODE_W-1:0] btn_code(input logic [NUM_BTN-1:0] onehot);
      logic [CODE_W-1:0] c;
      c = CODE_GREEN;
      if (onehot[1]) c = CODE_RED;
      if (onehot[2]) c = CODE_YELLOW;
      if (onehot[3]) c = CODE_BLUE;
      return c;
   endfunction

endpackage

// File: rtl/simon_btn_encoder_debounce.sv
// Single-button input path: two-flop synchroniser followed by a
// counter-based debouncer holding the filtered level.
module simon_btn_encoder_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic stable,
   output logic stable_nxt_c
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // A run of DEBOUNCE_CYCLES mismatching samples flips the level; any match restarts.
   always_comb begin
      stable_nxt_c = stable;
      cnt_nxt      = '0;
      if (sync2 != stable) begin
         if (cnt == CNT_LAST) begin
            stable_nxt_c = sync2;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync1  <= btn;
         sync2  <= sync1;
         cnt    <= cnt_nxt;
         stable <= stable_nxt_c;
      end
   end

endmodule

// File: rtl/simon_btn_encoder.sv
// Simon game input stage: debounces four buttons and emits one move code
// per press, flagging presses where more than one button is down.
module simon_btn_encoder
   import simon_btn_encoder_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn,
   output logic [CODE_W-1:0]  code,
   output logic               valid,
   output logic               multi_err,
   output logic               all_idle
);

   logic [NUM_BTN-1:0] stable;
   logic [NUM_BTN-1:0] stable_nxt;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
      simon_btn_encoder_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .clock        (clock),
         .reset        (reset),
         .btn          (btn[i]),
         .stable       (stable[i]),
         .stable_nxt_c (stable_nxt[i])
      );
   end

   state_t            state;
   state_t            state_nxt;
   logic [CODE_W-1:0] code_nxt;
   logic              valid_nxt;
   logic              multi_nxt;

   // Accept one press per IDLE visit, then wait until every button is released.
   always_comb begin
      state_nxt = state;
      code_nxt  = code;
      valid_nxt = 1'b0;
      multi_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (stable != '0) begin
               state_nxt = ST_WAIT_REL;
               if ($onehot(stable)) begin
                  valid_nxt = 1'b1;
                  code_nxt  = btn_code(stable);
               end else begin
                  multi_nxt = 1'b1;
               end
            end
         end
         ST_WAIT_REL: begin
            if (stable == '0) state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         code      <= CODE_GREEN;
         valid     <= 1'b0;
         multi_err <= 1'b0;
         all_idle  <= 1'b1;
      end else begin
         state     <= state_nxt;
         code      <= code_nxt;
         valid     <= valid_nxt;
         multi_err <= multi_nxt;
         all_idle  <= ~|stable_nxt;
      end
   end

endmodule
